fb_scanout: RTL and testbench
=============================

Name: fb_scanout

Overview:
- Parametrised framebuffer scanout engine for a single pixel clock.
- Generates framebuffer read addresses ahead of the beam, compensating for memory and CLUT latency.
- Supports runtime integer scaling, runtime placement, optional double buffering with tear-free swap, and background/blanking colour muxing.
- Sits between the display timing generator, the framebuffer BRAM + CLUT, and the registered VGA output.

Parameters:
- CORDW, 16, signed screen coordinate width.
- FB_WIDTH, 160, framebuffer width in pixels.
- FB_HEIGHT, 120, framebuffer height in pixels.
- SCALE_MAX, 4, largest supported scale factor (≥1).
- LAT_MEM, 2, cycles from fb_addr_read change to matching colr_in (BRAM + CLUT).
- DBUF, 1, 1 = two buffers in memory, 0 = single buffer.
- COLRW, 12, output colour width (3 × 4-bit channels).
- FB_ADDRW, $clog2(FB_WIDTH*FB_HEIGHT*(1+DBUF)), read address width.

Ports:
- clk_pix  in  1  pixel clock.
- rst_pix_n  in  1  asynchronous active-low reset.
- sx, sy  in  CORDW signed  current screen coordinates (sx increments by 1 per cycle within a line).
- de, hsync, vsync  in  1  timing from the display generator.
- frame, line  in  1  one-cycle pulses at the start of frame and start of line.
- pos_x, pos_y  in  CORDW signed  top-left screen position of the image.
- scale  in  $clog2(SCALE_MAX+1)  scale factor; 0 is treated as 1, values above SCALE_MAX clamp to SCALE_MAX.
- bg_colr  in  COLRW  colour outside the image.
- swap_req  in  1  request a buffer swap at the next frame.
- colr_in  in  COLRW  CLUT output for the address issued LAT_MEM cycles earlier.
- fb_addr_read  out  FB_ADDRW  framebuffer read address.
- buf_front  out  1  buffer currently displayed; writers target the other buffer.
- swap_done  out  1  one-cycle pulse when a swap takes effect.
- vga_hsync, vga_vsync  out  1  registered sync.
- vga_colr  out  COLRW  registered pixel colour.

Behaviour:
- Reset (asynchronous assert, synchronous release): all outputs 0; internal counters 0; shadow registers load pos 0 and scale 1; swap_pending 0.
- Shadowing:
  - On frame, sample pos_x, pos_y and scale (after the 0/clamp rules) into shadows.
  - Compute x_end = pos_x + FB_WIDTH*scale and y_end = pos_y + FB_HEIGHT*scale, each CORDW+1 bits signed so they cannot overflow.
  - Mid-frame changes to pos_x, pos_y and scale are ignored until the next frame.
- Lookahead:
  - In cycle t compute lx = sx(t) + LAT_MEM + 1.
  - rd_act = (shadow pos_y ≤ sy < y_end) and (pos_x ≤ lx < x_end).
- Horizontal:
  - On line pulse: col = 0, subx = 0.
  - While rd_act: register fb_addr_read = base + line_base + col at t+1.
  - Then subx++; when subx reaches scale-1, subx = 0 and col++.
  - Each address is held for exactly scale cycles.
- Vertical:
  - On line pulse with sy == pos_y: line_base = 0, suby = 0.
  - On line pulse with pos_y < sy < y_end: suby++; when suby reaches scale, suby = 0 and line_base += FB_WIDTH.
  - frame clears line_base and suby; frame takes priority over line in the same cycle.
- Outside rd_act, fb_addr_read holds its last value.
- Buffer base: base = buf_front ? FB_WIDTH*FB_HEIGHT : 0. With DBUF = 0, buf_front is tied to 0 and swap_done never asserts.
- Swap handshake:
  - swap_req (level or pulse) sets swap_pending.
  - On frame with (swap_pending | swap_req): toggle buf_front, pulse swap_done for one cycle, clear pending.
  - A swap_req in the same cycle as frame takes effect on that frame.
  - Repeated requests within a frame collapse into a single swap.
- Output stage:
  - paint = (pos_y ≤ sy < y_end) and (pos_x ≤ sx < x_end), evaluated on current sx/sy.
  - Next vga_colr = de ? (paint ? colr_in : bg_colr) : 0.
  - vga_hsync and vga_vsync are delayed one register to match vga_colr.
- Latency: colr_in aligns with the current sx; vga_* lag the sx/sy/de/hsync/vsync inputs by exactly 1 cycle.
- Reset mid-line: outputs drop to 0 immediately. Scanout resumes correctly from the first frame pulse after release; lines before that frame may show wrong addresses.

Decomposition:
- Package fb_pkg: the coordinate type, a colour struct (r, g, b of CHANW), and the FB_ADDRW/COLRW derivation functions.
- One sub-module, fb_addr_gen: the lookahead, col/subx/suby/line_base counters and buffer base.
- The top level holds the shadow registers, swap logic and output stage.

Test Plan:
- FB 160×120, scale 1, pos (0,0), LAT_MEM 2: at sy=0, sx=-3 → fb_addr_read=0 next cycle; addresses 0..159 over sx -3..156; sy=1 starts at 160; last pixel of the frame reads 19199.
- Scale 2: sy=0 and sy=1 both read 0..159 with each address held 2 cycles; sy=2 starts at 160; image spans sx 0..319, sy 0..239.
- pos (100,50), bg 'h137: sy=49 → vga_colr='h137 across the active line; sy=50, sx=99 → 'h137; sx=100 → colr_in; de=0 → 0.
- DBUF=1: swap_req pulse mid-frame → at next frame buf_front=1, swap_done=1 for one cycle; first address 19200. Three swap_req pulses within one frame → exactly one toggle.
- scale=0 → behaves as scale 1; scale=7 with SCALE_MAX 4 → behaves as 4. Change pos_x mid-frame → no visible shift until the next frame.
- Assert rst_pix_n low mid-line → vga_colr, vga_hsync, vga_vsync, fb_addr_read, buf_front = 0 immediately; after release, the first frame scans correctly from address 0.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and parameter derivations for the framebuffer scanout engine.
package fb_pkg;

    localparam int CHANW     = 4;
    localparam int CORDW_DEF = 16;

    typedef logic signed [CORDW_DEF-1:0] coord_t;

    typedef struct packed {
        logic [CHANW-1:0] r;
        logic [CHANW-1:0] g;
        logic [CHANW-1:0] b;
    } colr_t;

    typedef enum logic [0:0] {
        SWAP_IDLE = 1'b0,
        SWAP_PEND = 1'b1
    } swap_st_t;

    function automatic int calc_colrw(input int chanw);
        return 3 * chanw;
    endfunction

    function automatic int calc_fb_addrw(input int w, input int h, input int dbuf);
        return $clog2(w * h * (1 + dbuf));
    endfunction

endpackage

// File: rtl/fb_scanout_addr_gen.sv
// Read-address generator: looks ahead of the beam by the memory latency and
// walks column/row counters so each framebuffer pixel repeats scale times.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int SCALE_MAX = 4,
    parameter int LAT_MEM   = 2,
    parameter int FB_ADDRW  = 16,
    parameter int SCW       = $clog2(SCALE_MAX + 1)
) (
    input  logic                    clk_pix,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] i_sx,
    input  logic signed [CORDW-1:0] i_sy,
    input  logic                    i_frame,
    input  logic                    i_line,
    input  logic signed [CORDW-1:0] i_pos_x,
    input  logic signed [CORDW-1:0] i_pos_y,
    input  logic signed [CORDW:0]   i_x_end,
    input  logic signed [CORDW:0]   i_y_end,
    input  logic [SCW-1:0]          i_scale,
    input  logic                    i_buf_front,
    output logic [FB_ADDRW-1:0]     o_addr
);

    // Column counter must be able to hold FB_WIDTH after the last pixel of a row.
    localparam int COLW = $clog2(FB_WIDTH + 1);

    logic signed [CORDW:0] w_sy_e;
    logic signed [CORDW:0] w_px_e;
    logic signed [CORDW:0] w_py_e;
    logic signed [CORDW:0] w_lx;
    logic                  w_rd_act;
    logic [SCW-1:0]        w_scm1;
    logic [FB_ADDRW-1:0]   w_base;

    logic [COLW-1:0]       r_col;
    logic [SCW-1:0]        r_subx;
    logic [SCW-1:0]        r_suby;
    logic [FB_ADDRW-1:0]   r_line_base;
    logic [FB_ADDRW-1:0]   r_addr;

    logic [COLW-1:0]       w_col_nxt;
    logic [SCW-1:0]        w_subx_nxt;
    logic [SCW-1:0]        w_suby_nxt;
    logic [FB_ADDRW-1:0]   w_lb_nxt;
    logic [FB_ADDRW-1:0]   w_addr_nxt;

    assign w_sy_e   = {i_sy[CORDW-1], i_sy};
    assign w_px_e   = {i_pos_x[CORDW-1], i_pos_x};
    assign w_py_e   = {i_pos_y[CORDW-1], i_pos_y};
    assign w_lx     = {i_sx[CORDW-1], i_sx} + (CORDW+1)'(LAT_MEM + 1);
    assign w_rd_act = (w_py_e <= w_sy_e) && (w_sy_e < i_y_end) &&
                      (w_px_e <= w_lx)   && (w_lx < i_x_end);
    assign w_scm1   = i_scale - SCW'(1);
    assign o_addr   = r_addr;

    // Buffer base selection.
    always_comb begin
        w_base = {FB_ADDRW{1'b0}};
        if (i_buf_front) begin
            w_base = FB_ADDRW'(FB_WIDTH * FB_HEIGHT);
        end else begin
            w_base = {FB_ADDRW{1'b0}};
        end
    end

    // Horizontal counters and address issue.
    always_comb begin
        w_col_nxt  = r_col;
        w_subx_nxt = r_subx;
        w_addr_nxt = r_addr;
        if (w_rd_act) begin
            w_addr_nxt = w_base + r_line_base + FB_ADDRW'(r_col);
        end else begin
            w_addr_nxt = r_addr;
        end
        if (i_line) begin
            w_col_nxt  = {COLW{1'b0}};
            w_subx_nxt = {SCW{1'b0}};
        end else if (w_rd_act) begin
            if (r_subx == w_scm1) begin
                w_subx_nxt = {SCW{1'b0}};
                w_col_nxt  = r_col + COLW'(1);
            end else begin
                w_subx_nxt = r_subx + SCW'(1);
            end
        end else begin
            w_col_nxt  = r_col;
            w_subx_nxt = r_subx;
        end
    end

    // Vertical counters; frame wins over line, and rows only count inside the image.
    always_comb begin
        w_lb_nxt   = r_line_base;
        w_suby_nxt = r_suby;
        if (i_frame) begin
            w_lb_nxt   = {FB_ADDRW{1'b0}};
            w_suby_nxt = {SCW{1'b0}};
        end else if (i_line && (w_sy_e == w_py_e)) begin
            w_lb_nxt   = {FB_ADDRW{1'b0}};
            w_suby_nxt = {SCW{1'b0}};
        end else if (i_line && (w_py_e < w_sy_e) && (w_sy_e < i_y_end)) begin
            if (r_suby == w_scm1) begin
                w_suby_nxt = {SCW{1'b0}};
                w_lb_nxt   = r_line_base + FB_ADDRW'(FB_WIDTH);
            end else begin
                w_suby_nxt = r_suby + SCW'(1);
            end
        end else begin
            w_lb_nxt   = r_line_base;
            w_suby_nxt = r_suby;
        end
    end

    // Counter and address registers.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= {COLW{1'b0}};
            r_subx      <= {SCW{1'b0}};
            r_suby      <= {SCW{1'b0}};
            r_line_base <= {FB_ADDRW{1'b0}};
            r_addr      <= {FB_ADDRW{1'b0}};
        end else begin
            r_col       <= w_col_nxt;
            r_subx      <= w_subx_nxt;
            r_suby      <= w_suby_nxt;
            r_line_base <= w_lb_nxt;
            r_addr      <= w_addr_nxt;
        end
    end

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout top: per-frame shadowing of placement/scale, tear-free
// buffer swap and the registered VGA output stage.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int CORDW     = 16,
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int SCALE_MAX = 4,
    parameter int LAT_MEM   = 2,
    parameter int DBUF      = 1,
    parameter int COLRW     = calc_colrw(CHANW),
    parameter int FB_ADDRW  = calc_fb_addrw(FB_WIDTH, FB_HEIGHT, DBUF)
) (
    input  logic                               clk_pix,
    input  logic                               rst_pix_n,
    input  logic signed [CORDW-1:0]            sx,
    input  logic signed [CORDW-1:0]            sy,
    input  logic                               de,
    input  logic                               hsync,
    input  logic                               vsync,
    input  logic                               frame,
    input  logic                               line,
    input  logic signed [CORDW-1:0]            pos_x,
    input  logic signed [CORDW-1:0]            pos_y,
    input  logic [$clog2(SCALE_MAX+1)-1:0]     scale,
    input  logic [COLRW-1:0]                   bg_colr,
    input  logic                               swap_req,
    input  logic [COLRW-1:0]                   colr_in,
    output logic [FB_ADDRW-1:0]                fb_addr_read,
    output logic                               buf_front,
    output logic                               swap_done,
    output logic                               vga_hsync,
    output logic                               vga_vsync,
    output logic [COLRW-1:0]                   vga_colr
);

    localparam int SCW = $clog2(SCALE_MAX + 1);

    logic [SCW-1:0]          w_scale_eff;
    logic [CORDW-1:0]        w_xspan;
    logic [CORDW-1:0]        w_yspan;
    logic signed [CORDW:0]   w_x_end;
    logic signed [CORDW:0]   w_y_end;
    logic signed [CORDW:0]   w_sx_e;
    logic signed [CORDW:0]   w_sy_e;
    logic signed [CORDW:0]   w_px_e;
    logic signed [CORDW:0]   w_py_e;
    logic                    w_paint;
    logic [COLRW-1:0]        w_colr_nxt;
    logic                    w_buf_front;
    logic                    w_swap_done;

    logic signed [CORDW-1:0] r_pos_x;
    logic signed [CORDW-1:0] r_pos_y;
    logic [SCW-1:0]          r_scale;
    logic signed [CORDW:0]   r_x_end;
    logic signed [CORDW:0]   r_y_end;
    logic [COLRW-1:0]        r_colr;
    logic                    r_hsync;
    logic                    r_vsync;

    // Scale 0 means 1; anything above SCALE_MAX saturates.
    always_comb begin
        w_scale_eff = scale;
        if (scale == {SCW{1'b0}}) begin
            w_scale_eff = SCW'(1);
        end else if (scale > SCW'(SCALE_MAX)) begin
            w_scale_eff = SCW'(SCALE_MAX);
        end else begin
            w_scale_eff = scale;
        end
    end

    assign w_xspan = CORDW'(FB_WIDTH)  * CORDW'(w_scale_eff);
    assign w_yspan = CORDW'(FB_HEIGHT) * CORDW'(w_scale_eff);
    assign w_x_end = {pos_x[CORDW-1], pos_x} + {1'b0, w_xspan};
    assign w_y_end = {pos_y[CORDW-1], pos_y} + {1'b0, w_yspan};

    // Placement and scale shadows, reloaded only at frame start.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_pos_x <= {CORDW{1'b0}};
            r_pos_y <= {CORDW{1'b0}};
            r_scale <= SCW'(1);
            r_x_end <= (CORDW+1)'(FB_WIDTH);
            r_y_end <= (CORDW+1)'(FB_HEIGHT);
        end else if (frame) begin
            r_pos_x <= pos_x;
            r_pos_y <= pos_y;
            r_scale <= w_scale_eff;
            r_x_end <= w_x_end;
            r_y_end <= w_y_end;
        end else begin
            r_pos_x <= r_pos_x;
            r_pos_y <= r_pos_y;
            r_scale <= r_scale;
            r_x_end <= r_x_end;
            r_y_end <= r_y_end;
        end
    end

    generate
        if (DBUF != 0) begin : g_dbuf
            swap_st_t r_swap_st;
            swap_st_t w_swap_st_nxt;
            logic     w_toggle;
            logic     r_front;
            logic     r_done;

            // Swap request bookkeeping; requests collapse until the next frame.
            always_comb begin
                w_swap_st_nxt = r_swap_st;
                w_toggle      = 1'b0;
                case (r_swap_st)
                    SWAP_IDLE: begin
                        if (frame && swap_req) begin
                            w_toggle      = 1'b1;
                            w_swap_st_nxt = SWAP_IDLE;
                        end else if (swap_req) begin
                            w_swap_st_nxt = SWAP_PEND;
                        end else begin
                            w_swap_st_nxt = SWAP_IDLE;
                        end
                    end
                    SWAP_PEND: begin
                        if (frame) begin
                            w_toggle      = 1'b1;
                            w_swap_st_nxt = SWAP_IDLE;
                        end else begin
                            w_swap_st_nxt = SWAP_PEND;
                        end
                    end
                    default: begin
                        w_swap_st_nxt = SWAP_IDLE;
                    end
                endcase
            end

            // Swap state, front buffer and done pulse registers.
            always_ff @(posedge clk_pix or negedge rst_pix_n) begin
                if (!rst_pix_n) begin
                    r_swap_st <= SWAP_IDLE;
                    r_front   <= 1'b0;
                    r_done    <= 1'b0;
                end else begin
                    r_swap_st <= w_swap_st_nxt;
                    r_front   <= r_front ^ w_toggle;
                    r_done    <= w_toggle;
                end
            end

            assign w_buf_front = r_front;
            assign w_swap_done = r_done;
        end else begin : g_sbuf
            assign w_buf_front = 1'b0;
            assign w_swap_done = 1'b0;
        end
    endgenerate

    fb_addr_gen #(
        .CORDW     (CORDW),
        .FB_WIDTH  (FB_WIDTH),
        .FB_HEIGHT (FB_HEIGHT),
        .SCALE_MAX (SCALE_MAX),
        .LAT_MEM   (LAT_MEM),
        .FB_ADDRW  (FB_ADDRW),
        .SCW       (SCW)
    ) u_addr_gen (
        .clk_pix     (clk_pix),
        .rst_n       (rst_pix_n),
        .i_sx        (sx),
        .i_sy        (sy),
        .i_frame     (frame),
        .i_line      (line),
        .i_pos_x     (r_pos_x),
        .i_pos_y     (r_pos_y),
        .i_x_end     (r_x_end),
        .i_y_end     (r_y_end),
        .i_scale     (r_scale),
        .i_buf_front (w_buf_front),
        .o_addr      (fb_addr_read)
    );

    assign w_sx_e  = {sx[CORDW-1], sx};
    assign w_sy_e  = {sy[CORDW-1], sy};
    assign w_px_e  = {r_pos_x[CORDW-1], r_pos_x};
    assign w_py_e  = {r_pos_y[CORDW-1], r_pos_y};
    assign w_paint = (w_py_e <= w_sy_e) && (w_sy_e < r_y_end) &&
                     (w_px_e <= w_sx_e) && (w_sx_e < r_x_end);

    // Pixel colour mux: image, background, or black in blanking.
    always_comb begin
        w_colr_nxt = {COLRW{1'b0}};
        if (!de) begin
            w_colr_nxt = {COLRW{1'b0}};
        end else if (w_paint) begin
            w_colr_nxt = colr_in;
        end else begin
            w_colr_nxt = bg_colr;
        end
    end

    // Output registers, sync delayed to line up with colour.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            r_colr  <= {COLRW{1'b0}};
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_colr  <= w_colr_nxt;
            r_hsync <= hsync;
            r_vsync <= vsync;
        end
    end

    assign vga_colr  = r_colr;
    assign vga_hsync = r_hsync;
    assign vga_vsync = r_vsync;
    assign buf_front = w_buf_front;
    assign swap_done = w_swap_done;

endmodule

// File: tb/tb_fb_scanout.sv
// Self-checking bench for fb_scanout: frame-level table plus a per-cycle
// arithmetic reference model of addresses, colour mux and swap behaviour.
module tb_fb_scanout;
    import fb_pkg::*;

    localparam int CORDW = 16;
    localparam int FBW   = 160;
    localparam int FBH   = 120;
    localparam int SMAX  = 4;
    localparam int LAT   = 2;
    localparam int COLRW = 12;
    localparam int ADDRW = 16;
    localparam int H_ACT = 640;
    localparam int V_ACT = 480;

    logic                    clk_pix = 1'b0;
    logic                    rst_pix_n;
    logic signed [CORDW-1:0] sx, sy, pos_x, pos_y;
    logic                    de, hsync, vsync, frame, line, swap_req;
    logic [2:0]              scale;
    logic [COLRW-1:0]        bg_colr, colr_in;
    logic [ADDRW-1:0]        fb_addr_read;
    logic                    buf_front, swap_done, vga_hsync, vga_vsync;
    logic [COLRW-1:0]        vga_colr;

    fb_scanout dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .sx(sx), .sy(sy), .de(de),
        .hsync(hsync), .vsync(vsync), .frame(frame), .line(line),
        .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .bg_colr(bg_colr),
        .swap_req(swap_req), .colr_in(colr_in), .fb_addr_read(fb_addr_read),
        .buf_front(buf_front), .swap_done(swap_done), .vga_hsync(vga_hsync),
        .vga_vsync(vga_vsync), .vga_colr(vga_colr)
    );

    always #5 clk_pix = ~clk_pix;

    int n_cmp = 0;
    int n_bad = 0;
    int cur_x = 0;
    int cur_y = 0;

    // Reference model state: shadows, swap state, expected held address.
    int m_px, m_py, m_sc, m_xe, m_ye, m_front, m_pend, m_addr;
    int first_paint, last_paint;

    typedef struct {
        int px; int py; int sc; int bg; int nsw;
        int exp_first; int exp_last; int exp_front; int exp_end_addr;
    } vec_t;
    vec_t tbl[5];

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            if (n_bad <= 30)
                $display("FAIL %s: got %0d want %0d (sx=%0d sy=%0d)", name, act, exp, cur_x, cur_y);
        end
    endtask

    task automatic model_reset();
        m_px = 0; m_py = 0; m_sc = 1; m_xe = FBW; m_ye = FBH;
        m_front = 0; m_pend = 0; m_addr = 0;
    endtask

    task automatic step(input int x, input int y, input bit ln, input bit fr,
                        input bit sw, input bit prb);
        int lx, eff;
        bit paint;
        logic [COLRW-1:0] e_colr;
        bit e_hs, e_vs, e_sd;
        cur_x = x; cur_y = y;
        sx = CORDW'(x); sy = CORDW'(y);
        line = ln; frame = fr; swap_req = sw;
        de = (x >= 0 && x < H_ACT && y >= 0 && y < V_ACT);
        hsync = (x < -24);
        vsync = (y < 0);
        colr_in = prb ? ~bg_colr : COLRW'($urandom);
        paint  = (y >= m_py && y < m_ye && x >= m_px && x < m_xe);
        e_colr = de ? (paint ? colr_in : bg_colr) : '0;
        e_hs = hsync; e_vs = vsync;
        lx = x + LAT + 1;
        if (y >= m_py && y < m_ye && lx >= m_px && lx < m_xe)
            m_addr = m_front * FBW * FBH + ((y - m_py) / m_sc) * FBW + (lx - m_px) / m_sc;
        e_sd = 0;
        if (fr && (m_pend != 0 || sw)) begin
            m_front = 1 - m_front; e_sd = 1; m_pend = 0;
        end else if (sw) begin
            m_pend = 1;
        end
        if (fr) begin
            eff = (scale == 0) ? 1 : ((int'(scale) > SMAX) ? SMAX : int'(scale));
            m_px = int'(pos_x); m_py = int'(pos_y); m_sc = eff;
            m_xe = m_px + FBW * eff; m_ye = m_py + FBH * eff;
        end
        @(posedge clk_pix); #1;
        cmp("vga_colr", int'(vga_colr), int'(e_colr));
        cmp("vga_hsync", int'(vga_hsync), int'(e_hs));
        cmp("vga_vsync", int'(vga_vsync), int'(e_vs));
        cmp("fb_addr_read", int'(fb_addr_read), m_addr);
        cmp("buf_front", int'(buf_front), m_front);
        cmp("swap_done", int'(swap_done), int'(e_sd));
        if (prb && de && vga_colr == ~bg_colr) begin
            if (first_paint < -100) first_paint = x;
            last_paint = x;
        end
        if (fr) begin
            pos_x = CORDW'($urandom_range(0, 400));
            pos_y = CORDW'($urandom_range(0, 300));
            scale = 3'($urandom_range(0, 7));
        end
    endtask

    task automatic run_line(input int y, input bit full, input bit fr, input int nsw, input bit prb);
        int xend;
        bit sw;
        xend = full ? ((m_xe + 2 < 700) ? m_xe + 2 : 700) : -28;
        for (int x = -32; x <= xend; x++) begin
            sw = (nsw > 0 && x == -31) || (nsw > 1 && x == -29) || (nsw > 2 && x == -27);
            step(x, y, x == -32, fr && x == -32, sw, prb);
        end
    endtask

    task automatic run_frame(input int px, input int py, input int sc, input int bg, input int nsw);
        int mid;
        bit full;
        pos_x = CORDW'(px); pos_y = CORDW'(py); scale = 3'(sc); bg_colr = COLRW'(bg);
        run_line(-1, 1'b0, 1'b1, 0, 1'b0);
        mid = m_py + (m_ye - m_py) / 2;
        first_paint = -1000; last_paint = -1000;
        for (int y = 0; y < m_ye; y++) begin
            full = (y == m_py - 1) || (y == m_py) || (y == m_py + 1) || (y == m_ye - 1) || (y == mid);
            run_line(y, full, 1'b0, (y == m_py + 1) ? nsw : 0, y == m_py);
        end
    endtask

    initial begin
        colr_t c137;
        c137 = '{r: 4'h1, g: 4'h3, b: 4'h7};
        tbl[0] = '{0,   0,  1, 'h2a5, 0, 0, 159, 0, 19199};
        tbl[1] = '{0,   0,  2, 'h0f0, 1, 0, 319, 0, 19199};
        tbl[2] = '{100, 50, 0, int'(c137), 3, 100, 259, 1, 38399};
        tbl[3] = '{-10, 10, 7, 'h800, 0, 0, 629, 0, 19199};
        tbl[4] = '{20,  30, 3, 'h05a, 0, 20, 499, 0, 19199};

        rst_pix_n = 1'b0;
        sx = '0; sy = '0; de = 0; hsync = 0; vsync = 0; frame = 0; line = 0;
        pos_x = '0; pos_y = '0; scale = 3'd1; bg_colr = '0; swap_req = 0; colr_in = '0;
        model_reset();
        repeat (3) @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;
        cmp("rst_colr", int'(vga_colr), 0);
        cmp("rst_addr", int'(fb_addr_read), 0);
        cmp("rst_front", int'(buf_front), 0);
        cmp("rst_done", int'(swap_done), 0);
        cmp("rst_hsync", int'(vga_hsync), 0);
        cmp("rst_vsync", int'(vga_vsync), 0);

        for (int i = 0; i < 5; i++) begin
            run_frame(tbl[i].px, tbl[i].py, tbl[i].sc, tbl[i].bg, tbl[i].nsw);
            cmp($sformatf("t%0d_first_paint", i), first_paint, tbl[i].exp_first);
            cmp($sformatf("t%0d_last_paint", i), last_paint, tbl[i].exp_last);
            cmp($sformatf("t%0d_front", i), int'(buf_front), tbl[i].exp_front);
            cmp($sformatf("t%0d_end_addr", i), int'(fb_addr_read), tbl[i].exp_end_addr);
        end

        // swap_req coincident with frame, then reset in the middle of a line
        pos_x = '0; pos_y = '0; scale = 3'd1; bg_colr = 12'h0f0;
        step(-32, -1, 1'b1, 1'b1, 1'b1, 1'b0);
        cmp("swap_with_frame", int'(buf_front), 1);
        for (int x = -31; x <= 50; x++) step(x, 0, x == -32, 1'b0, 1'b0, 1'b0);
        #2 rst_pix_n = 1'b0;
        #1;
        cmp("midrst_colr", int'(vga_colr), 0);
        cmp("midrst_hsync", int'(vga_hsync), 0);
        cmp("midrst_vsync", int'(vga_vsync), 0);
        cmp("midrst_addr", int'(fb_addr_read), 0);
        cmp("midrst_front", int'(buf_front), 0);
        model_reset();
        @(posedge clk_pix); @(posedge clk_pix);
        #1 rst_pix_n = 1'b1;
        run_frame(0, 0, 1, 'h321, 0);
        cmp("postrst_end_addr", int'(fb_addr_read), 19199);
        cmp("postrst_front", int'(buf_front), 0);

        for (int f = 0; f < 4; f++) begin
            run_frame($urandom_range(0, 60) - 20, $urandom_range(0, 20),
                      $urandom_range(0, 7), $urandom_range(0, 4095), $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
